usr_sequencer: RTL and testbench
================================

# usr_sequencer

Command-driven controller for the 4-bit universal shift register datapath: it accepts one command at a time (parallel load, shift right, shift left, rotate right) and drives the shared 2-bit mux select bus and the serial fill bits for the required number of cycles. It sits between the lab control logic (switches/FSM) and the register's per-bit 4-to-1 select muxes, replacing hand-driven select lines.

## Interface
- `WIDTH`, default 4: register width; sizes `load_data`, `par_out`, `usr_q`.
- `CNT_W`, default 3: width of the shift count; maximum count is 2^CNT_W−1.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 2: 00 LOAD, 01 SHR, 10 SHL, 11 ROTR.
- `cmd_count` in CNT_W: number of shift cycles; ignored for LOAD.
- `cmd_fill` in 1: serial fill bit for SHR/SHL.
- `load_data` in WIDTH: parallel data for LOAD.
- `usr_q` in WIDTH: current register contents, used for rotate feedback.
- `sel` out 2: mux select to all bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `ser_r` out 1: serial input entering the MSB on a right shift.
- `ser_l` out 1: serial input entering the LSB on a left shift.
- `par_out` out WIDTH: parallel-load value presented to the register.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- The FSM has three states:
  - IDLE → RUN on handshake (`cmd_valid && cmd_ready`), or IDLE → DONE when an accepted shift has count 0.
  - RUN → DONE when the remaining count reaches 1 (last active cycle).
  - DONE → IDLE unconditionally.
- On handshake, latch `cmd_op`, `cmd_fill`, `load_data`, and count. LOAD forces count = 1.
- Select during RUN by latched op:
  - LOAD: `sel`=11.
  - SHR: `sel`=01, `ser_r`=fill.
  - SHL: `sel`=10, `ser_l`=fill.
  - ROTR: `sel`=01, `ser_r`=`usr_q[0]` (combinational feedback).
- In IDLE and DONE, `sel`=00 (hold).
- `ser_r`/`ser_l` are 0 whenever not in use. `par_out` holds the latched `load_data`.
- `cmd_ready` = (state == IDLE) && !`reset`. `busy` = (state != IDLE).
- Commands presented while busy are not accepted and stay pending on the input; no queueing.
- Rotate left by N is issued by software as ROTR by WIDTH−N. The block does not reduce counts modulo WIDTH; a count greater than WIDTH simply rotates further.

## Timing
- Reset values: `sel`=00, `ser_r`=0, `ser_l`=0, `par_out`=0, `busy`=0, `done`=0, state IDLE, internal counter 0. `cmd_ready`=0 while `reset` is high, and 1 in the first cycle after reset deasserts.
- For a handshake at edge k with count N ≥ 1:
  - `sel` is active in cycles k+1 … k+N.
  - `done`=1 in cycle k+N+1.
  - `cmd_ready` is high again in cycle k+N+2.
  - Latency from accept to done is N+1 cycles.
- Count 0 (SHR/SHL/ROTR): `done`=1 in cycle k+1 with `sel`=00 throughout.
- Back-to-back commands: the earliest next accept is the edge ending cycle k+N+2. `cmd_ready` never rises in the DONE cycle.
- Reset mid-RUN: the next cycle is IDLE, `sel`=00, and no `done` pulse. The register keeps its partially shifted value.
- `sel`, `ser_l`, `par_out`, `done`, and `busy` are registered. `ser_r` is registered for SHR but combinational from `usr_q` for ROTR.

## Structure
- Shared package `usr_pkg` holds:
  - op encodings `OP_LOAD`/`OP_SHR`/`OP_SHL`/`OP_ROTR`;
  - select encodings `SEL_HOLD`/`SEL_SHR`/`SEL_SHL`/`SEL_LOAD`;
  - FSM state encodings `S_IDLE`/`S_RUN`/`S_DONE`.
- Sub-module `usr_shift_counter` is a loadable CNT_W-bit down-counter with a `last` flag (count == 1) and a `zero` flag. The FSM uses `last` for RUN→DONE and `zero` for the count-0 bypass.
- Expected size is about 150–250 lines of RTL, excluding the package.

## Test plan
- LOAD with `load_data`=1011 → `sel`=11 for exactly 1 cycle, `par_out`=1011; the register model reads 1011; `done` pulses 2 cycles after accept.
- Register at 1011, SHR count 2, fill 0 → `sel`=01 for 2 cycles; register reads 0010; `done` in cycle k+3.
- Register at 1011, ROTR count 1 → `ser_r`=1 during the active cycle; register reads 1101. ROTR count 4 returns 1011.
- SHL count 0 → `sel` stays 00, `done` in cycle k+1, `cmd_ready` high in k+2; the register is unchanged.
- `cmd_valid` held high continuously with SHL count 3 → second accept occurs exactly at k+5 (N+2), not earlier; no command is dropped or duplicated.
- `reset` asserted in the 2nd cycle of SHR count 5 → next cycle `sel`=00, `busy`=0, no `done`; `cmd_ready`=1 after `reset` drops.

Source files
------------

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared encodings for the universal shift register sequencer
package usr_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_SHR  = 2'b01,
    SEL_SHL  = 2'b10,
    SEL_LOAD = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Rotate right reuses the shift-right mux path; only the serial source differs.
  function automatic sel_e op_to_sel(input op_e op);
    case (op)
      OP_LOAD: return SEL_LOAD;
      OP_SHL:  return SEL_SHL;
      default: return SEL_SHR;
    endcase
  endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// rtl/usr_shift_counter.sv - loadable down-counter with last/zero flags
module usr_shift_counter #(
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last,
  output logic             o_zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_last = (r_cnt == ONE);
  // Zero looks at the value being loaded so the accept cycle can bypass RUN.
  assign o_zero = ((i_load ? i_load_val : r_cnt) == '0);

endmodule

// File: rtl/usr_sequencer.sv
// rtl/usr_sequencer.sv - command sequencer driving the 4-bit universal shift register
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_count,
  input  logic             i_cmd_fill,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic [WIDTH-1:0] i_usr_q,
  output logic [1:0]       o_sel,
  output logic             o_ser_r,
  output logic             o_ser_l,
  output logic [WIDTH-1:0] o_par_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] LOAD_COUNT = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic             r_fill;
  logic [WIDTH-1:0] r_data;
  sel_e             r_sel;
  logic             r_ser_r;
  logic             r_ser_l;
  logic             r_rot;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  op_e              w_op_cur;
  logic             w_fill_cur;
  logic [CNT_W-1:0] w_load_val;
  logic             w_cnt_last;
  logic             w_cnt_zero;
  sel_e             w_sel_nxt;
  logic             w_ser_r_nxt;
  logic             w_ser_l_nxt;
  logic             w_rot_nxt;
  logic             w_unused_q;

  assign o_cmd_ready = (r_state == S_IDLE) && !i_reset;
  assign w_accept    = i_cmd_valid && o_cmd_ready;

  // Command fields as they will be seen next cycle: fresh on accept, latched otherwise.
  assign w_op_cur   = w_accept ? op_e'(i_cmd_op) : r_op;
  assign w_fill_cur = w_accept ? i_cmd_fill : r_fill;
  assign w_load_val = (op_e'(i_cmd_op) == OP_LOAD) ? LOAD_COUNT : i_cmd_count;

  usr_shift_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      (r_state == S_RUN),
    .o_last     (w_cnt_last),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_cnt_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_cnt_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they appear registered in the cycle they apply.
  always_comb begin
    w_sel_nxt   = SEL_HOLD;
    w_ser_r_nxt = 1'b0;
    w_ser_l_nxt = 1'b0;
    w_rot_nxt   = 1'b0;
    if (w_state_nxt == S_RUN) begin
      w_sel_nxt = op_to_sel(w_op_cur);
      case (w_op_cur)
        OP_SHR:  w_ser_r_nxt = w_fill_cur;
        OP_SHL:  w_ser_l_nxt = w_fill_cur;
        OP_ROTR: w_rot_nxt   = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_LOAD;
      r_fill  <= 1'b0;
      r_data  <= '0;
      r_sel   <= SEL_HOLD;
      r_ser_r <= 1'b0;
      r_ser_l <= 1'b0;
      r_rot   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ser_r <= w_ser_r_nxt;
      r_ser_l <= w_ser_l_nxt;
      r_rot   <= w_rot_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_op   <= op_e'(i_cmd_op);
        r_fill <= i_cmd_fill;
        r_data <= i_load_data;
      end
    end
  end

  assign o_sel     = r_sel;
  // Rotate feeds the LSB straight back so each cycle sees the freshly shifted register.
  assign o_ser_r   = r_rot ? i_usr_q[0] : r_ser_r;
  assign o_ser_l   = r_ser_l;
  assign o_par_out = r_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

  assign w_unused_q = ^i_usr_q[WIDTH-1:1];

endmodule

// File: tb/tb_usr_sequencer.sv
// tb/tb_usr_sequencer.sv - self-checking bench for usr_sequencer with a register datapath model
module tb_usr_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_count = 3'd0;
  logic       cmd_fill = 1'b0;
  logic [3:0] load_data = 4'd0;
  logic [3:0] dp_q = 4'd0;
  logic [1:0] sel;
  logic       ser_r;
  logic       ser_l;
  logic [3:0] par_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  usr_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_count (cmd_count),
    .i_cmd_fill  (cmd_fill),
    .i_load_data (load_data),
    .i_usr_q     (dp_q),
    .o_sel       (sel),
    .o_ser_r     (ser_r),
    .o_ser_l     (ser_l),
    .o_par_out   (par_out),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  // The 4-bit universal shift register itself, driven by the sequencer outputs.
  always @(posedge clk) begin
    case (sel)
      2'b01:   dp_q <= {ser_r, dp_q[3:1]};
      2'b10:   dp_q <= {dp_q[2:0], ser_l};
      2'b11:   dp_q <= par_out;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Final register contents after a whole command, from closed-form arithmetic.
  function automatic logic [3:0] ref_result(input logic [1:0] op, input int n, input logic fill,
                                            input logic [3:0] data, input logic [3:0] q);
    int r;
    logic [3:0] fm;
    case (op)
      2'b00: return data;
      2'b01: begin
        if (n >= 4) return {4{fill}};
        fm = fill ? 4'((15 << (4 - n)) & 15) : 4'd0;
        return 4'(q >> n) | fm;
      end
      2'b10: begin
        if (n >= 4) return {4{fill}};
        fm = fill ? 4'((1 << n) - 1) : 4'd0;
        return 4'(q << n) | fm;
      end
      default: begin
        r = n % 4;
        return 4'((q >> r) | (q << (4 - r)));
      end
    endcase
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic fill, input logic [3:0] data);
    int n;
    logic [3:0] exp_q;
    logic [1:0] exp_sel;
    n = (op == 2'b00) ? 1 : int'(cnt);
    exp_q = ref_result(op, n, fill, data, dp_q);
    exp_sel = (op == 2'b00) ? 2'b11 : (op == 2'b10) ? 2'b10 : 2'b01;
    chk("ready_before_cmd", {7'd0, cmd_ready}, 8'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_count = cnt;
    cmd_fill = fill;
    load_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_count = 3'($urandom);
    cmd_fill = 1'($urandom);
    load_data = 4'($urandom);
    for (int c = 1; c <= n + 1; c++) begin
      if (c <= n) begin
        chk("sel_active", {6'd0, sel}, {6'd0, exp_sel});
        chk("busy_active", {7'd0, busy}, 8'd1);
        chk("done_early", {7'd0, done}, 8'd0);
        chk("ready_active", {7'd0, cmd_ready}, 8'd0);
        chk("ser_r_active", {7'd0, ser_r},
            {7'd0, (op == 2'b01) ? fill : (op == 2'b11) ? dp_q[0] : 1'b0});
        chk("ser_l_active", {7'd0, ser_l}, {7'd0, (op == 2'b10) ? fill : 1'b0});
        if (op == 2'b00) chk("par_out_load", {4'd0, par_out}, {4'd0, data});
      end else begin
        chk("done_pulse", {7'd0, done}, 8'd1);
        chk("sel_done_hold", {6'd0, sel}, 8'd0);
        chk("ready_in_done", {7'd0, cmd_ready}, 8'd0);
        chk("busy_in_done", {7'd0, busy}, 8'd1);
        chk("ser_idle", {6'd0, ser_r, ser_l}, 8'd0);
      end
      @(negedge clk);
    end
    chk("ready_after", {7'd0, cmd_ready}, 8'd1);
    chk("done_after", {7'd0, done}, 8'd0);
    chk("busy_after", {7'd0, busy}, 8'd0);
    chk("sel_after", {6'd0, sel}, 8'd0);
    chk("reg_result", {4'd0, dp_q}, {4'd0, exp_q});
    chk("par_out_latched", {4'd0, par_out}, {4'd0, data});
  endtask

  initial begin
    logic [3:0] exp_q;
    int na;
    int nd;
    int acc[2];

    repeat (3) @(negedge clk);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd0);
    chk("rst_sel", {6'd0, sel}, 8'd0);
    chk("rst_ser", {6'd0, ser_r, ser_l}, 8'd0);
    chk("rst_par_out", {4'd0, par_out}, 8'd0);
    chk("rst_busy_done", {6'd0, busy, done}, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {7'd0, cmd_ready}, 8'd1);

    run_cmd(2'b00, 3'd5, 1'b0, 4'b1011);
    chk("load_1011", {4'd0, dp_q}, 8'h0b);
    run_cmd(2'b01, 3'd2, 1'b0, 4'b0000);
    chk("shr2_0010", {4'd0, dp_q}, 8'h02);
    run_cmd(2'b00, 3'd0, 1'b0, 4'b1011);
    run_cmd(2'b11, 3'd1, 1'b0, 4'b0110);
    chk("rotr1_1101", {4'd0, dp_q}, 8'h0d);
    run_cmd(2'b00, 3'd0, 1'b0, 4'b1011);
    run_cmd(2'b11, 3'd4, 1'b0, 4'b0000);
    chk("rotr4_1011", {4'd0, dp_q}, 8'h0b);
    run_cmd(2'b10, 3'd0, 1'b1, 4'b0101);
    chk("shl0_unchanged", {4'd0, dp_q}, 8'h0b);
    run_cmd(2'b11, 3'd7, 1'b0, 4'b0000);
    chk("rotr7_0111", {4'd0, dp_q}, 8'h07);

    // Valid held high across two commands: the second accept must land N+2 cycles later.
    exp_q = ref_result(2'b10, 6, 1'b1, 4'd0, dp_q);
    na = 0;
    nd = 0;
    acc[0] = -1;
    acc[1] = -1;
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_count = 3'd3;
    cmd_fill = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (done) nd++;
      if (cmd_valid && cmd_ready) begin
        if (na < 2) acc[na] = c;
        na++;
      end
      @(negedge clk);
      if (na >= 2) cmd_valid = 1'b0;
    end
    chk("b2b_accepts", 8'(na), 8'd2);
    chk("b2b_first_at_0", 8'(acc[0]), 8'd0);
    chk("b2b_second_at_5", 8'(acc[1]), 8'd5);
    chk("b2b_done_count", 8'(nd), 8'd2);
    chk("b2b_reg", {4'd0, dp_q}, {4'd0, exp_q});

    // Reset during the second active cycle of a long shift.
    run_cmd(2'b00, 3'd0, 1'b0, 4'b1011);
    exp_q = ref_result(2'b01, 2, 1'b1, 4'd0, dp_q);
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_count = 3'd5;
    cmd_fill = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rstrun_sel_c1", {6'd0, sel}, 8'h01);
    @(negedge clk);
    chk("rstrun_sel_c2", {6'd0, sel}, 8'h01);
    reset = 1'b1;
    #1;
    chk("rstrun_ready_low", {7'd0, cmd_ready}, 8'd0);
    @(negedge clk);
    chk("rstrun_sel_hold", {6'd0, sel}, 8'd0);
    chk("rstrun_busy", {7'd0, busy}, 8'd0);
    chk("rstrun_no_done", {7'd0, done}, 8'd0);
    chk("rstrun_ready_in_rst", {7'd0, cmd_ready}, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstrun_ready_after", {7'd0, cmd_ready}, 8'd1);
    chk("rstrun_no_done2", {7'd0, done}, 8'd0);
    chk("rstrun_partial_reg", {4'd0, dp_q}, {4'd0, exp_q});

    for (int i = 0; i < 14; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
